// File: rtl/waveform_gen.sv
// rtl/waveform_gen.sv - triangle / ramp-up / ramp-down sample generator with valid/ready output and window counter
module waveform_gen #(
    parameter int WIDTH     = 10,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [1:0]           cfg_mode,
    input  logic [WIDTH-1:0]     cfg_peak,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    output logic                 out_last,
    output logic [CNT_WIDTH-1:0] win_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]     ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0]     ZERO     = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [1:0]           MODE_RUP = 2'd1;
    localparam logic [1:0]           MODE_RDN = 2'd2;

    state_t           state;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] peak_q;

    // Start-of-window values derived straight from the live config inputs.
    logic [WIDTH-1:0] start_peak;
    logic [WIDTH-1:0] start_data;
    state_t           start_state;

    logic [WIDTH-1:0] inc_data;
    logic [WIDTH-1:0] dec_data;
    logic             mode_tri;
    logic             mode_rup;

    always_comb begin
        start_peak  = (cfg_peak == ZERO) ? ONE : cfg_peak;
        start_state = (cfg_mode == MODE_RDN) ? DOWN : UP;
        start_data  = (cfg_mode == MODE_RDN) ? start_peak : ZERO;
    end

    // out_data stays within 0..peak_q, so neither neighbour can wrap when used.
    assign inc_data = out_data + ONE;
    assign dec_data = out_data - ONE;
    assign mode_rup = (mode_q == MODE_RUP);
    assign mode_tri = (mode_q != MODE_RUP) && (mode_q != MODE_RDN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= ZERO;
            win_count <= '0;
            mode_q    <= 2'd0;
            peak_q    <= ONE;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        mode_q    <= cfg_mode;
                        peak_q    <= start_peak;
                        state     <= start_state;
                        out_valid <= 1'b1;
                        out_data  <= start_data;
                        out_last  <= 1'b0;
                    end
                end
                UP, DOWN: begin
                    if (out_ready) begin
                        if (out_last) begin
                            win_count <= win_count + CNT_ONE;
                            if (en) begin
                                mode_q    <= cfg_mode;
                                peak_q    <= start_peak;
                                state     <= start_state;
                                out_valid <= 1'b1;
                                out_data  <= start_data;
                                out_last  <= 1'b0;
                            end else begin
                                state     <= IDLE;
                                out_valid <= 1'b0;
                                out_data  <= ZERO;
                                out_last  <= 1'b0;
                            end
                        end else if (state == UP) begin
                            // Only a triangle reaches the peak without being last: turn around.
                            if (out_data == peak_q) begin
                                state    <= DOWN;
                                out_data <= dec_data;
                                out_last <= (dec_data == ONE);
                            end else begin
                                out_data <= inc_data;
                                out_last <= (inc_data == peak_q) && (mode_rup || peak_q == ONE);
                            end
                        end else begin
                            out_data <= dec_data;
                            out_last <= mode_tri ? (dec_data == ONE) : (dec_data == ZERO);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_data  <= ZERO;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_waveform_gen.sv
// tb/tb_waveform_gen.sv - self-checking bench for waveform_gen against a sample-list reference model
module tb_waveform_gen;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en;
    logic       sel;
    logic       out_ready;
    logic [1:0] cfg_mode;
    int         peak_i;

    logic [9:0]  peak_a;
    logic [3:0]  peak_b;
    logic        en_a, en_b;
    logic [9:0]  data_a;
    logic        valid_a, last_a;
    logic [15:0] wc_a;
    logic [3:0]  data_b;
    logic        valid_b, last_b;
    logic [2:0]  wc_b;

    assign peak_a = peak_i[9:0];
    assign peak_b = peak_i[3:0];
    assign en_a   = en & ~sel;
    assign en_b   = en & sel;

    waveform_gen #(.WIDTH(10), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .cfg_mode(cfg_mode), .cfg_peak(peak_a),
        .out_ready(out_ready), .out_data(data_a), .out_valid(valid_a), .out_last(last_a),
        .win_count(wc_a)
    );

    waveform_gen #(.WIDTH(4), .CNT_WIDTH(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .cfg_mode(cfg_mode), .cfg_peak(peak_b),
        .out_ready(out_ready), .out_data(data_b), .out_valid(valid_b), .out_last(last_b),
        .win_count(wc_b)
    );

    int checks   = 0;
    int failures = 0;

    bit m_active;
    int m_q[$];
    int m_wc[2];

    function automatic void fill_window(input int mode, input int peak_raw);
        int p;
        p = sel ? (peak_raw % 16) : (peak_raw % 1024);
        if (p == 0) p = 1;
        m_q.delete();
        if (mode == 1) begin
            for (int v = 0; v <= p; v++) m_q.push_back(v);
        end else if (mode == 2) begin
            for (int v = p; v >= 0; v--) m_q.push_back(v);
        end else begin
            for (int v = 0; v <= p; v++) m_q.push_back(v);
            for (int v = p - 1; v >= 1; v--) m_q.push_back(v);
        end
    endfunction

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [15:0] exp_data, exp_wc;
        exp_data = m_active ? 16'(m_q[0]) : 16'd0;
        exp_wc   = sel ? 16'(m_wc[1] % 8) : 16'(m_wc[0] % 65536);
        if (sel) begin
            check_eq("valid_b", {15'd0, valid_b}, {15'd0, m_active});
            check_eq("data_b", {12'd0, data_b}, exp_data);
            check_eq("last_b", {15'd0, last_b}, {15'd0, m_active && m_q.size() == 1});
            check_eq("wc_b", {13'd0, wc_b}, exp_wc);
        end else begin
            check_eq("valid_a", {15'd0, valid_a}, {15'd0, m_active});
            check_eq("data_a", {6'd0, data_a}, exp_data);
            check_eq("last_a", {15'd0, last_a}, {15'd0, m_active && m_q.size() == 1});
            check_eq("wc_a", wc_a, exp_wc);
        end
    endtask

    // Apply what the next rising edge will see to the model.
    task automatic model_update();
        if (!m_active) begin
            if (en) begin
                fill_window(int'(cfg_mode), peak_i);
                m_active = 1'b1;
            end
        end else if (out_ready) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
                m_wc[int'(sel)]++;
                if (en) fill_window(int'(cfg_mode), peak_i);
                else m_active = 1'b0;
            end
        end
    endtask

    task automatic step(input bit e, input int m, input int p, input bit r);
        check_outputs();
        en        = e;
        cfg_mode  = 2'(m);
        peak_i    = p;
        out_ready = r;
        model_update();
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b1);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_valid_a", {15'd0, valid_a}, 16'd0);
        check_eq("rst_data_a", {6'd0, data_a}, 16'd0);
        check_eq("rst_last_a", {15'd0, last_a}, 16'd0);
        check_eq("rst_wc_a", wc_a, 16'd0);
        check_eq("rst_valid_b", {15'd0, valid_b}, 16'd0);
        check_eq("rst_wc_b", {13'd0, wc_b}, 16'd0);
        m_active = 1'b0;
        m_q.delete();
        m_wc[0] = 0;
        m_wc[1] = 0;
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; sel = 1'b0; cfg_mode = 2'd0; peak_i = 0; out_ready = 1'b0;
        m_active = 1'b0; m_wc[0] = 0; m_wc[1] = 0;
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // Reset mid-window, then restart from 0.
        step(1'b1, 0, 3, 1'b1);
        step(1'b1, 0, 3, 1'b1);
        step(1'b1, 0, 3, 1'b1);
        do_reset();
        step(1'b0, 0, 3, 1'b1);
        step(1'b0, 0, 3, 1'b1);

        // Triangle P=3 back to back, then graceful stop.
        for (int i = 0; i < 7; i++) step(1'b1, 0, 3, 1'b1);
        check_eq("tri3_wc_after_first", wc_a, 16'd1);
        check_eq("tri3_restart_zero", {6'd0, data_a}, 16'd0);
        drain(10);

        // Ramp-up P=2 with out_ready toggling.
        for (int i = 0; i < 10; i++) step(i == 0, 1, 2, (i % 2) == 0);
        drain(4);

        // Ramp-down P=4 with en dropped after the start.
        step(1'b1, 2, 4, 1'b1);
        step(1'b1, 2, 4, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 2, 4, 1'b1);
        check_eq("rdn4_idle", {15'd0, valid_a}, 16'd0);

        // Peak changed 3 -> 5 mid-window.
        step(1'b1, 0, 3, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 0, (i < 2) ? 3 : 5, 1'b1);
        drain(14);

        // Peak 0 treated as 1, P=1 shapes, and full-scale ramp.
        step(1'b1, 0, 0, 1'b1);
        step(1'b1, 2, 1, 1'b1);
        step(1'b1, 2, 1, 1'b1);
        drain(4);
        step(1'b1, 1, 1023, 1'b1);
        drain(1030);

        // Randomized traffic on the 10-bit block.
        for (int i = 0; i < 700; i++)
            step($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 12),
                 $urandom_range(0, 3) != 0);
        drain(30);

        // 4-bit block: P=15 ramp, then counter wrap.
        sel = 1'b1;
        step(1'b1, 1, 15, 1'b1);
        drain(20);
        for (int i = 0; i < 24; i++) step(1'b1, 0, 1, 1'b1);
        drain(4);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 15),
                 $urandom_range(0, 3) != 0);
        do_reset();
        for (int i = 0; i < 100; i++)
            step($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 15),
                 $urandom_range(0, 3) != 0);
        drain(35);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
